// File: rtl/stall_ctl.sv
// Pipeline interlock for the mips789 core: decides whether the ID stage may
// advance, injects ID/EX bubbles, and tracks the multi-cycle mul/div unit.
module stall_ctl #(
    parameter int MD_CYCLES = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_rn,
    input  logic [4:0]  id_rt_rn,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_is_branch,
    input  logic        id_md_rd,
    input  logic        id_md_start,
    input  logic [4:0]  ex_wr_rn,
    input  logic        ex_we,
    input  logic        ex_is_load,
    input  logic [4:0]  mem_wr_rn,
    input  logic        mem_we,
    input  logic        mem_is_load,
    input  logic        md_start,
    input  logic        ext_pause,
    output logic        pause,
    output logic        id_ex_clr,
    output logic        md_busy,
    output logic [1:0]  stall_state,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LD     = 2'd1;
    localparam logic [1:0] ST_MD     = 2'd2;
    localparam logic [1:0] ST_FROZEN = 2'd3;
    localparam logic [5:0] MD_LOAD   = 6'(MD_CYCLES);

    logic [5:0] md_cnt;
    logic       ld_ex, br_ex, br_mem, md_hz, ld_haz, haz;

    // r0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic reg_match(
        input logic [4:0] rn,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return ((use_rs && rs == rn) || (use_rt && rt == rn)) && (rn != 5'd0);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        ld_ex  = ex_we && ex_is_load &&
                 reg_match(ex_wr_rn, id_rs_rn, id_rt_rn, id_use_rs, id_use_rt);
        br_ex  = id_is_branch && ex_we &&
                 reg_match(ex_wr_rn, id_rs_rn, id_rt_rn, id_use_rs, id_use_rt);
        br_mem = id_is_branch && mem_we && mem_is_load &&
                 reg_match(mem_wr_rn, id_rs_rn, id_rt_rn, id_use_rs, id_use_rt);
        md_hz  = md_busy && (id_md_rd || id_md_start);
        ld_haz = ld_ex || br_ex || br_mem;
        haz    = ld_haz || md_hz;
    end

    // A frozen pipe holds ID/EX, so no bubble is needed while ext_pause is high.
    always_comb begin
        pause     = haz || ext_pause;
        id_ex_clr = haz && !ext_pause;
        if (ext_pause)
            stall_state = ST_FROZEN;
        else if (md_hz)
            stall_state = ST_MD;
        else if (ld_haz)
            stall_state = ST_LD;
        else
            stall_state = ST_RUN;
    end

    assign md_busy = (md_cnt != 6'd0);

    // The mul/div unit runs free: a new start always reloads, freezes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            md_cnt <= 6'd0;
        else if (md_start)
            md_cnt <= MD_LOAD;
        else if (md_cnt != 6'd0)
            md_cnt <= md_cnt - 6'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= 16'd0;
        else if (id_ex_clr)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_stall_ctl.sv
// Directed-vector bench for stall_ctl with MD_CYCLES=4; expected values are
// hand-computed per cycle.
module tb_stall_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs_rn, id_rt_rn, ex_wr_rn, mem_wr_rn;
    logic        id_use_rs, id_use_rt, id_is_branch, id_md_rd, id_md_start;
    logic        ex_we, ex_is_load, mem_we, mem_is_load, md_start, ext_pause;
    logic        pause, id_ex_clr, md_busy;
    logic [1:0]  stall_state;
    logic [15:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    stall_ctl #(.MD_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs_rn(id_rs_rn), .id_rt_rn(id_rt_rn),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_branch(id_is_branch), .id_md_rd(id_md_rd), .id_md_start(id_md_start),
        .ex_wr_rn(ex_wr_rn), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .mem_wr_rn(mem_wr_rn), .mem_we(mem_we), .mem_is_load(mem_is_load),
        .md_start(md_start), .ext_pause(ext_pause),
        .pause(pause), .id_ex_clr(id_ex_clr), .md_busy(md_busy),
        .stall_state(stall_state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        id_rs_rn = 0; id_rt_rn = 0; id_use_rs = 0; id_use_rt = 0;
        id_is_branch = 0; id_md_rd = 0; id_md_start = 0;
        ex_wr_rn = 0; ex_we = 0; ex_is_load = 0;
        mem_wr_rn = 0; mem_we = 0; mem_is_load = 0;
        md_start = 0; ext_pause = 0;
    endtask

    // advance one clock; inputs are then driven 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic p, input logic c, input logic [1:0] s);
        #1;
        check({tag, ".pause"}, 32'(pause), 32'(p));
        check({tag, ".clr"}, 32'(id_ex_clr), 32'(c));
        check({tag, ".state"}, 32'(stall_state), 32'(s));
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #3;
        outs("reset", 0, 0, 0);
        check("reset.busy", 32'(md_busy), 0);
        check("reset.cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // load-use: lw r5 in EX, add with rs=5 in ID
        ex_we = 1; ex_is_load = 1; ex_wr_rn = 5; id_use_rs = 1; id_rs_rn = 5;
        outs("ldu", 1, 1, 1);
        step();
        idle(); mem_we = 1; mem_is_load = 1; mem_wr_rn = 5; id_use_rs = 1; id_rs_rn = 5;
        outs("ldu_rel", 0, 0, 0);
        check("ldu.cnt", 32'(stall_cnt), 1);
        step();

        // branch on load: beq r7 with lw r7 in EX then MEM
        idle(); id_is_branch = 1; id_use_rs = 1; id_rs_rn = 7;
        ex_we = 1; ex_is_load = 1; ex_wr_rn = 7;
        outs("brld1", 1, 1, 1);
        step();
        ex_we = 0; ex_is_load = 0; ex_wr_rn = 0;
        mem_we = 1; mem_is_load = 1; mem_wr_rn = 7;
        outs("brld2", 1, 1, 1);
        step();
        mem_we = 0; mem_is_load = 0; mem_wr_rn = 0;
        outs("brld_rel", 0, 0, 0);
        check("brld.cnt", 32'(stall_cnt), 3);

        // branch on ALU result (rt=9): one bubble, then forwarded from MEM
        idle(); id_is_branch = 1; id_use_rt = 1; id_rt_rn = 9;
        ex_we = 1; ex_wr_rn = 9;
        outs("bralu", 1, 1, 1);
        step();
        ex_we = 0; ex_wr_rn = 0; mem_we = 1; mem_wr_rn = 9;
        outs("bralu_rel", 0, 0, 0);
        check("bralu.cnt", 32'(stall_cnt), 4);
        step();

        // r0 destination and unused operand never stall
        idle(); ex_we = 1; ex_is_load = 1; ex_wr_rn = 0; id_use_rs = 1; id_rs_rn = 0;
        id_is_branch = 1;
        outs("r0", 0, 0, 0);
        idle(); ex_we = 1; ex_is_load = 1; ex_wr_rn = 5;
        id_use_rs = 1; id_rs_rn = 3; id_use_rt = 0; id_rt_rn = 5;
        outs("unused_rt", 0, 0, 0);
        step();

        // mul/div: md_start at T, mfhi in ID from T+1, release at T+5
        idle(); md_start = 1;
        outs("md_T", 0, 0, 0);
        step();
        md_start = 0; id_md_rd = 1;
        for (int i = 1; i <= 4; i++) begin
            outs($sformatf("md_T%0d", i), 1, 1, 2);
            check($sformatf("md_T%0d.busy", i), 32'(md_busy), 1);
            step();
        end
        outs("md_rel", 0, 0, 0);
        check("md_rel.busy", 32'(md_busy), 0);
        check("md.cnt", 32'(stall_cnt), 8);

        // freeze overlapping a load-use hazard while mul/div keeps counting
        idle(); md_start = 1;
        step();
        md_start = 0; ext_pause = 1;
        ex_we = 1; ex_is_load = 1; ex_wr_rn = 4; id_use_rs = 1; id_rs_rn = 4;
        outs("frz1", 1, 0, 3);
        step();
        outs("frz2", 1, 0, 3);
        step();
        idle();
        check("frz.cnt", 32'(stall_cnt), 8);
        check("frz.busyD", 32'(md_busy), 1);
        step();
        #1 check("frz.busyE", 32'(md_busy), 1);
        step();
        check("frz.busyF", 32'(md_busy), 0);

        // restart while busy reloads the counter
        md_start = 1;
        step();
        md_start = 0;
        step();
        md_start = 1;
        step();
        md_start = 0;
        step(); step();
        #1 check("restart.busyF", 32'(md_busy), 1);
        step();
        check("restart.busyG", 32'(md_busy), 1);
        step();
        check("restart.busyH", 32'(md_busy), 0);

        // asynchronous reset with md_cnt == 2
        md_start = 1;
        step();
        md_start = 0;
        step(); step();
        check("rstmid.pre_busy", 32'(md_busy), 1);
        #2 rst = 1'b0;
        #1;
        check("rstmid.busy", 32'(md_busy), 0);
        check("rstmid.cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // saturation of the bubble counter
        ex_we = 1; ex_is_load = 1; ex_wr_rn = 5; id_use_rs = 1; id_rs_rn = 5;
        repeat (65534) @(posedge clk);
        #1 check("sat.fffe", 32'(stall_cnt), 32'hFFFE);
        repeat (6) @(posedge clk);
        #1 check("sat.ffff", 32'(stall_cnt), 32'hFFFF);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
